// File: rtl/ifetch_bridge.sv
// Instruction fetch bridge: serves the fetch stage from a one-entry buffer
// and refills it through a variable-latency req/ack bus on a miss, with a
// bus timeout and a pipeline flush.
module ifetch_bridge #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        core_ce_i,
   input  logic [31:0] core_addr_i,
   output logic [31:0] core_inst_o,
   output logic        core_stall_o,
   input  logic        flush_i,
   output logic        bus_req_o,
   output logic [31:0] bus_addr_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        fetch_err_o,
   output logic        fault_o
);

   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state, state_nxt;
   logic        buf_valid, buf_valid_nxt;
   logic [31:0] buf_addr, buf_addr_nxt;
   logic [31:0] buf_data, buf_data_nxt;
   logic [7:0]  wait_cnt, wait_cnt_nxt;
   logic        flush_pend, flush_pend_nxt;
   logic        bus_req_nxt;
   logic [31:0] bus_addr_nxt;
   logic        fetch_err_nxt;
   logic        fault_nxt;
   logic        hit;

   // A flush in the same cycle always forces a miss.
   assign hit = buf_valid && (buf_addr == core_addr_i) && !flush_i;

   // Fetch-side response: buffered word on a hit, stall on a miss.
   always_comb begin
      core_inst_o  = NOP_WORD;
      core_stall_o = 1'b0;
      if (core_ce_i) begin
         if (hit) begin
            core_inst_o = buf_data;
         end else begin
            core_stall_o = 1'b1;
         end
      end
   end

   // Next-state logic: start a transaction on a miss, finish it on ack or timeout.
   always_comb begin
      state_nxt      = state;
      buf_valid_nxt  = buf_valid;
      buf_addr_nxt   = buf_addr;
      buf_data_nxt   = buf_data;
      wait_cnt_nxt   = wait_cnt;
      flush_pend_nxt = flush_pend;
      bus_req_nxt    = bus_req_o;
      bus_addr_nxt   = bus_addr_o;
      fetch_err_nxt  = 1'b0;
      fault_nxt      = fault_o;
      case (state)
         IDLE: begin
            flush_pend_nxt = 1'b0;
            if (flush_i) begin
               buf_valid_nxt = 1'b0;
            end
            if (core_ce_i && !hit) begin
               bus_addr_nxt = core_addr_i;
               bus_req_nxt  = 1'b1;
               wait_cnt_nxt = 8'd0;
               state_nxt    = WAIT;
            end
         end
         WAIT: begin
            // A flush anywhere in the transaction invalidates its result,
            // but the bus handshake still runs to completion.
            if (flush_i) begin
               buf_valid_nxt  = 1'b0;
               flush_pend_nxt = 1'b1;
            end
            if (bus_ack_i) begin
               buf_data_nxt  = bus_rdata_i;
               buf_addr_nxt  = bus_addr_o;
               buf_valid_nxt = !(flush_pend || flush_i);
               bus_req_nxt   = 1'b0;
               state_nxt     = IDLE;
            end else if (wait_cnt == LAST_CNT) begin
               buf_data_nxt  = NOP_WORD;
               buf_addr_nxt  = bus_addr_o;
               buf_valid_nxt = !(flush_pend || flush_i);
               bus_req_nxt   = 1'b0;
               fetch_err_nxt = 1'b1;
               fault_nxt     = 1'b1;
               state_nxt     = IDLE;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         default: begin
            state_nxt   = IDLE;
            bus_req_nxt = 1'b0;
         end
      endcase
   end

   // State register; reset drops any bus transaction immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         buf_valid   <= 1'b0;
         buf_addr    <= 32'd0;
         buf_data    <= 32'd0;
         wait_cnt    <= 8'd0;
         flush_pend  <= 1'b0;
         bus_req_o   <= 1'b0;
         bus_addr_o  <= 32'd0;
         fetch_err_o <= 1'b0;
         fault_o     <= 1'b0;
      end else begin
         state       <= state_nxt;
         buf_valid   <= buf_valid_nxt;
         buf_addr    <= buf_addr_nxt;
         buf_data    <= buf_data_nxt;
         wait_cnt    <= wait_cnt_nxt;
         flush_pend  <= flush_pend_nxt;
         bus_req_o   <= bus_req_nxt;
         bus_addr_o  <= bus_addr_nxt;
         fetch_err_o <= fetch_err_nxt;
         fault_o     <= fault_nxt;
      end
   end

endmodule

// File: tb/tb_ifetch_bridge.sv
// Bench for ifetch_bridge: table of fetch transactions plus hand-written
// sequences for flush, mid-WAIT address change and asynchronous reset.
module tb_ifetch_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        core_ce_i = 1'b0;
   logic [31:0] core_addr_i = 32'd0;
   logic [31:0] core_inst_o;
   logic        core_stall_o;
   logic        flush_i = 1'b0;
   logic        bus_req_o;
   logic [31:0] bus_addr_o;
   logic        bus_ack_i = 1'b0;
   logic [31:0] bus_rdata_i = 32'd0;
   logic        fetch_err_o;
   logic        fault_o;

   int checks = 0;
   int errors = 0;

   ifetch_bridge #(.TIMEOUT(16), .NOP_WORD(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .core_ce_i(core_ce_i), .core_addr_i(core_addr_i),
      .core_inst_o(core_inst_o), .core_stall_o(core_stall_o),
      .flush_i(flush_i),
      .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o),
      .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
      .fetch_err_o(fetch_err_o), .fault_o(fault_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          k;          // ack in the k-th req cycle (0-based); 255 = never
      logic [31:0] rdata;
      int          exp_stall;
      int          exp_req;
      logic [31:0] exp_inst;
      logic        exp_err;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 ns later.
   task automatic do_fetch(input logic [31:0] addr, input int k, input logic [31:0] rdata,
                           output int stall_n, output int req_n, output logic [31:0] inst,
                           output logic err, output logic addr_ok, output logic done);
      stall_n = 0; req_n = 0; inst = 32'hx; err = 1'bx; addr_ok = 1'b1; done = 1'b0;
      @(negedge clk);
      core_ce_i   = 1'b1;
      core_addr_i = addr;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clk);
         bus_ack_i   = 1'b0;
         bus_rdata_i = 32'd0;
         if (bus_req_o) begin
            if (bus_addr_o !== addr) addr_ok = 1'b0;
            if (req_n == k) begin
               bus_ack_i   = 1'b1;
               bus_rdata_i = rdata;
            end
            req_n++;
         end
         #1;
         if (core_stall_o) begin
            stall_n++;
         end else begin
            inst = core_inst_o;
            err  = fetch_err_o;
            done = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int          st, rq;
      logic [31:0] inst;
      logic        err, aok, done;

      vecs[0] = '{32'h0000_0000, 0,   32'h3401_1100, 2,  1,  32'h3401_1100, 1'b0};
      vecs[1] = '{32'h0000_0004, 2,   32'h1111_1111, 4,  3,  32'h1111_1111, 1'b0};
      vecs[2] = '{32'h0000_0008, 2,   32'h2222_2222, 4,  3,  32'h2222_2222, 1'b0};
      vecs[3] = '{32'h0000_0008, 0,   32'hFFFF_FFFF, 0,  0,  32'h2222_2222, 1'b0};
      vecs[4] = '{32'h0000_000C, 255, 32'hFFFF_FFFF, 17, 16, 32'h0000_0000, 1'b1};
      vecs[5] = '{32'h0000_000C, 0,   32'hFFFF_FFFF, 0,  0,  32'h0000_0000, 1'b0};
      vecs[6] = '{32'h0000_0040, 5,   32'hDEAD_BEEF, 7,  6,  32'hDEAD_BEEF, 1'b0};

      // Reset state
      #12;
      chk("rst_req", 32'(bus_req_o), 32'd0);
      chk("rst_addr", bus_addr_o, 32'd0);
      chk("rst_err", 32'(fetch_err_o), 32'd0);
      chk("rst_fault", 32'(fault_o), 32'd0);
      chk("rst_inst", core_inst_o, 32'd0);
      chk("rst_stall", 32'(core_stall_o), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Ack while idle must not fill the buffer
      @(negedge clk);
      bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_5555;
      #1;
      chk("idle_ack_req", 32'(bus_req_o), 32'd0);
      @(negedge clk);
      bus_ack_i = 1'b0; bus_rdata_i = 32'd0;

      for (int i = 0; i < 7; i++) begin
         do_fetch(vecs[i].addr, vecs[i].k, vecs[i].rdata, st, rq, inst, err, aok, done);
         chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
         chk($sformatf("v%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
         chk($sformatf("v%0d_req", i), 32'(rq), 32'(vecs[i].exp_req));
         chk($sformatf("v%0d_inst", i), inst, vecs[i].exp_inst);
         chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
         chk($sformatf("v%0d_addr_stable", i), 32'(aok), 32'd1);
      end
      chk("fault_sticky", 32'(fault_o), 32'd1);

      // Fetch disabled returns NOP without stall even on a buffered address
      @(negedge clk);
      core_ce_i = 1'b0;
      #1;
      chk("ce0_inst", core_inst_o, 32'd0);
      chk("ce0_stall", 32'(core_stall_o), 32'd0);

      // Flush in the same cycle as ack: result not valid, same address misses again
      @(negedge clk);
      core_ce_i = 1'b1; core_addr_i = 32'h0000_0100;
      #1; chk("fl_miss", 32'(core_stall_o), 32'd1);
      @(negedge clk);
      chk("fl_req", 32'(bus_req_o), 32'd1);
      bus_ack_i = 1'b1; bus_rdata_i = 32'hAAAA_5555; flush_i = 1'b1;
      #1; chk("fl_ack_stall", 32'(core_stall_o), 32'd1);
      @(negedge clk);
      bus_ack_i = 1'b0; flush_i = 1'b0;
      #1;
      chk("fl_after_stall", 32'(core_stall_o), 32'd1);
      chk("fl_after_req", 32'(bus_req_o), 32'd0);
      @(negedge clk);
      chk("fl_rereq", 32'(bus_req_o), 32'd1);
      chk("fl_readdr", bus_addr_o, 32'h0000_0100);
      bus_ack_i = 1'b1; bus_rdata_i = 32'hBBBB_0000;
      @(negedge clk);
      bus_ack_i = 1'b0;
      #1;
      chk("fl_hit_stall", 32'(core_stall_o), 32'd0);
      chk("fl_hit_inst", core_inst_o, 32'hBBBB_0000);

      // Address change mid-WAIT is ignored; the new address gets its own transaction
      @(negedge clk);
      core_addr_i = 32'h0000_0010;
      @(negedge clk);
      core_addr_i = 32'h0000_0020;
      #1; chk("mw_addr0", bus_addr_o, 32'h0000_0010);
      @(negedge clk);
      chk("mw_addr1", bus_addr_o, 32'h0000_0010);
      bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_1010;
      @(negedge clk);
      bus_ack_i = 1'b0;
      #1;
      chk("mw_new_stall", 32'(core_stall_o), 32'd1);
      chk("mw_new_req0", 32'(bus_req_o), 32'd0);
      @(negedge clk);
      chk("mw_new_req", 32'(bus_req_o), 32'd1);
      chk("mw_new_addr", bus_addr_o, 32'h0000_0020);
      bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_2020;
      @(negedge clk);
      bus_ack_i = 1'b0;
      #1;
      chk("mw_hit_inst", core_inst_o, 32'h0000_2020);
      chk("mw_hit_stall", 32'(core_stall_o), 32'd0);

      // Flush in IDLE turns a hit into a miss
      @(negedge clk);
      flush_i = 1'b1;
      #1; chk("fi_stall", 32'(core_stall_o), 32'd1);
      @(negedge clk);
      flush_i = 1'b0;
      chk("fi_req", 32'(bus_req_o), 32'd1);
      bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_2021;
      @(negedge clk);
      bus_ack_i = 1'b0;
      #1; chk("fi_inst", core_inst_o, 32'h0000_2021);

      // Asynchronous reset mid-WAIT drops the request without a clock edge
      @(negedge clk);
      core_addr_i = 32'h0000_0030;
      @(negedge clk);
      chk("ar_req_before", 32'(bus_req_o), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("ar_req_dropped", 32'(bus_req_o), 32'd0);
      chk("ar_fault_clear", 32'(fault_o), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("ar_first_miss", 32'(core_stall_o), 32'd1);
      @(negedge clk);
      chk("ar_req_again", 32'(bus_req_o), 32'd1);
      bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_3030;
      @(negedge clk);
      bus_ack_i = 1'b0;
      #1;
      chk("ar_inst", core_inst_o, 32'h0000_3030);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
